// File: rtl/move_gen_pkg.sv
// -----------------------------------------------------------------------------
// move_gen_pkg
// Shared types and helpers for the move generator.
//   state_t        : generator FSM states (IDLE/PICK/PROBE/DONE)
//   NUM_INPUTS_DEF : default number of player inputs
//   IDX_W          : bits needed to index NUM_INPUTS_DEF inputs; also the
//                    default field width consumed per element pick
//   clamp_1_to()   : clamps a count into the range 1..hi
// -----------------------------------------------------------------------------
package move_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_INPUTS_DEF = 13;
    localparam int IDX_W          = $clog2(NUM_INPUTS_DEF);

    // Zero is promoted to one so a level always has at least one input/element.
    function automatic logic [3:0] clamp_1_to(input logic [3:0] v, input logic [3:0] hi);
        if (v == 4'd0) begin
            return 4'd1;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/move_gen_if.sv
// -----------------------------------------------------------------------------
// move_gen_if
// Handshake bundle between the round controller (master) and the move
// generator (slave).
//   start        : request a new move (master -> slave)
//   rng          : random word, latched on an accepted start
//   num_play     : active inputs this level
//   num_elements : elements per move
//   move         : generated mask, stable while valid (slave -> master)
//   busy         : generation in progress
//   done         : one-cycle completion pulse
//   valid        : move is final, held until the next accepted start
// -----------------------------------------------------------------------------
interface move_gen_if #(
    parameter int RNG_W      = 32,
    parameter int NUM_INPUTS = 13
);
    logic                  start;
    logic [RNG_W-1:0]      rng;
    logic [3:0]            num_play;
    logic [2:0]            num_elements;
    logic [NUM_INPUTS-1:0] move;
    logic                  busy;
    logic                  done;
    logic                  valid;

    modport master (
        output start, rng, num_play, num_elements,
        input  move, busy, done, valid
    );

    modport slave (
        input  start, rng, num_play, num_elements,
        output move, busy, done, valid
    );
endinterface

// File: rtl/move_gen_mod_reduce.sv
// -----------------------------------------------------------------------------
// mod_reduce
// Combinational remainder field % modulus using a restoring long-division
// chain: one compare/subtract stage per field bit, no divider.
//   field   : FIELD_W-bit dividend
//   modulus : MW-bit divisor, must be non-zero
//   rem     : remainder, always < modulus
// -----------------------------------------------------------------------------
module mod_reduce #(
    parameter int FIELD_W = 4,
    parameter int MW      = FIELD_W + 1
) (
    input  logic [FIELD_W-1:0] field,
    input  logic [MW-1:0]      modulus,
    output logic [MW-1:0]      rem
);
    // part_rem[i] holds the remainder of the top i field bits; it stays below
    // modulus, so shifting in one more bit never exceeds MW+1 bits.
    logic [MW-1:0] part_rem [FIELD_W+1];

    assign part_rem[0] = '0;

    for (genvar gi = 0; gi < FIELD_W; gi++) begin : g_step
        logic [MW:0] trial;
        assign trial = {part_rem[gi], field[FIELD_W-1-gi]};
        // trial < 2*modulus, so one conditional subtract restores the bound;
        // the difference fits MW bits, hence the narrow subtraction.
        assign part_rem[gi+1] = (trial >= {1'b0, modulus}) ? (trial[MW-1:0] - modulus)
                                                           : trial[MW-1:0];
    end

    assign rem = part_rem[FIELD_W];

endmodule

// File: rtl/move_gen.sv
// -----------------------------------------------------------------------------
// move_gen
// Turns a latched random word into a move mask over NUM_INPUTS player inputs.
// Element k uses field k of the word, reduced modulo the active input count.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : move_gen_if.slave (start/rng/num_play/num_elements in,
//           move/busy/done/valid out)
// Build option MOVE_DISTINCT_EN: when defined, colliding picks probe upward
// (wrapping at the active input count) so the mask always holds exactly the
// requested number of distinct bits. When undefined, collisions merge and the
// move completes in exactly 1+elem cycles.
// -----------------------------------------------------------------------------
module move_gen
    import move_gen_pkg::*;
#(
    parameter int RNG_W      = 32,
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int FIELD_W    = IDX_W,
    parameter int MAX_ELEM   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    move_gen_if.slave bus
);
    localparam int MW         = FIELD_W + 1;
    localparam int NUM_FIELDS = RNG_W / FIELD_W;
    // num_play is 4 bits wide, so play can never exceed 15.
    localparam logic [3:0] PLAY_MAX = (NUM_INPUTS > 15) ? 4'd15 : 4'(NUM_INPUTS);
    localparam logic [3:0] ELEM_MAX = (MAX_ELEM > 15) ? 4'd15 : 4'(MAX_ELEM);
    localparam logic [NUM_INPUTS-1:0] ONE_HOT0 = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [RNG_W-1:0]      rng_reg, rng_next;
    logic [3:0]            play_reg, play_next;
    logic [3:0]            elem_reg, elem_next;
    logic [3:0]            k_reg, k_next;
    logic [NUM_INPUTS-1:0] move_reg, move_next;
    logic                  busy_reg, busy_next;
    logic                  valid_reg, valid_next;

    logic [FIELD_W-1:0]    field_arr [NUM_FIELDS];
    logic [FIELD_W-1:0]    field_sel;
    logic [MW-1:0]         play_ext;
    logic [MW-1:0]         cand;
    logic [NUM_INPUTS-1:0] cand_hot;
    logic [3:0]            k_inc;
    logic [3:0]            play_c;
    logic [3:0]            elem_hi;

`ifdef MOVE_DISTINCT_EN
    logic [MW-1:0]         cand_reg, cand_next;
    logic [NUM_INPUTS-1:0] probe_hot;
    logic [MW-1:0]         cand_inc;
    logic [MW-1:0]         probe_inc;
`endif

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        assign field_arr[gi] = rng_reg[gi*FIELD_W +: FIELD_W];
    end

    always_comb begin
        field_sel = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (k_reg == 4'(i)) begin
                field_sel = field_arr[i];
            end
        end
    end

    assign play_ext = MW'(play_reg);

    mod_reduce #(
        .FIELD_W (FIELD_W),
        .MW      (MW)
    ) u_mod_reduce (
        .field   (field_sel),
        .modulus (play_ext),
        .rem     (cand)
    );

    // cand < play <= NUM_INPUTS, so the shifted bit always lands in range.
    assign cand_hot = ONE_HOT0 << cand;
    assign k_inc    = k_reg + 4'd1;

`ifdef MOVE_DISTINCT_EN
    assign probe_hot = ONE_HOT0 << cand_reg;
    assign cand_inc  = cand + MW'(1);
    assign probe_inc = cand_reg + MW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rng_reg   <= '0;
            play_reg  <= '0;
            elem_reg  <= '0;
            k_reg     <= '0;
            move_reg  <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
`ifdef MOVE_DISTINCT_EN
            cand_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            rng_reg   <= rng_next;
            play_reg  <= play_next;
            elem_reg  <= elem_next;
            k_reg     <= k_next;
            move_reg  <= move_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
`ifdef MOVE_DISTINCT_EN
            cand_reg  <= cand_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        rng_next   = rng_reg;
        play_next  = play_reg;
        elem_next  = elem_reg;
        k_next     = k_reg;
        move_next  = move_reg;
        busy_next  = busy_reg;
        valid_next = valid_reg;
        play_c     = clamp_1_to(bus.num_play, PLAY_MAX);
        elem_hi    = (ELEM_MAX < play_c) ? ELEM_MAX : play_c;
`ifdef MOVE_DISTINCT_EN
        cand_next  = cand_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    rng_next   = bus.rng;
                    play_next  = play_c;
                    elem_next  = clamp_1_to({1'b0, bus.num_elements}, elem_hi);
                    move_next  = '0;
                    k_next     = '0;
                    valid_next = 1'b0;
                    busy_next  = 1'b1;
                    state_next = PICK;
                end
            end

            PICK: begin
`ifdef MOVE_DISTINCT_EN
                if ((move_reg & cand_hot) != '0) begin
                    cand_next  = (cand_inc == play_ext) ? '0 : cand_inc;
                    state_next = PROBE;
                end else begin
                    move_next  = move_reg | cand_hot;
                    k_next     = k_inc;
                    state_next = (k_inc == elem_reg) ? DONE : PICK;
                end
`else
                move_next  = move_reg | cand_hot;
                k_next     = k_inc;
                state_next = (k_inc == elem_reg) ? DONE : PICK;
`endif
            end

`ifdef MOVE_DISTINCT_EN
            PROBE: begin
                // elem <= play guarantees a free slot, so this loop terminates.
                if ((move_reg & probe_hot) != '0) begin
                    cand_next = (probe_inc == play_ext) ? '0 : probe_inc;
                end else begin
                    move_next  = move_reg | probe_hot;
                    k_next     = k_inc;
                    state_next = (k_inc == elem_reg) ? DONE : PICK;
                end
            end
`endif

            DONE: begin
                valid_next = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.move  = move_reg;
    assign bus.busy  = busy_reg;
    assign bus.valid = valid_reg;
    assign bus.done  = (state_reg == DONE);

endmodule

// File: tb/tb_move_gen.sv
// -----------------------------------------------------------------------------
// tb_move_gen
// Directed testbench for move_gen (NUM_INPUTS=13, RNG_W=32). Expected masks
// and latencies are hand-computed; both MOVE_DISTINCT_EN builds are covered.
// -----------------------------------------------------------------------------
module tb_move_gen;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    move_gen_if #(.RNG_W(32), .NUM_INPUTS(13)) bus ();

    move_gen #(
        .RNG_W      (32),
        .NUM_INPUTS (13),
        .FIELD_W    (4),
        .MAX_ELEM   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start at a negedge and returns at the negedge of the cycle
    // where done is high; lat counts cycles after the accepting edge.
    task automatic start_and_wait(input logic [31:0] r, input logic [3:0] p,
                                  input logic [2:0] e, output int lat);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.rng          = r;
        bus.num_play     = p;
        bus.num_elements = e;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.move !== 13'h0) $display("FAIL reset_move got=%h exp=%h", bus.move, 13'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL idle_hold_busy got=%b exp=0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        start_and_wait(32'h0000_0021, 4'd13, 3'd2, lat);
        total_cnt++;
        if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.move !== 13'h0006) $display("FAIL basic_move got=%h exp=%h", bus.move, 13'h0006);
        else pass_cnt++;
        total_cnt++;
        if ($countones(bus.move) !== 2) $display("FAIL basic_popcount got=%0d exp=2", $countones(bus.move));
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL basic_valid got valid=%b busy=%b exp valid=1 busy=0", bus.valid, bus.busy);
        else pass_cnt++;
        $display("basic: rng=00000021 play=13 elem=2 move=%h lat=%0d", bus.move, lat);
    endtask

    task automatic test_collision();
        int lat;
        logic [12:0] exp_move;
        int exp_lat;
`ifdef MOVE_DISTINCT_EN
        exp_move = 13'h0006; exp_lat = 4;
`else
        exp_move = 13'h0002; exp_lat = 3;
`endif
        start_and_wait(32'h0000_0011, 4'd13, 3'd2, lat);
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL collision_latency got=%0d exp=%0d", lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.move !== exp_move) $display("FAIL collision_move got=%h exp=%h", bus.move, exp_move);
        else pass_cnt++;
        $display("collision: rng=00000011 play=13 elem=2 move=%h lat=%0d", bus.move, lat);
    endtask

    task automatic test_probe_wrap();
        int lat;
        logic [12:0] exp_move;
        int exp_lat;
`ifdef MOVE_DISTINCT_EN
        exp_move = 13'h0009; exp_lat = 4;
`else
        exp_move = 13'h0008; exp_lat = 3;
`endif
        start_and_wait(32'h0000_0033, 4'd4, 3'd2, lat);
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL wrap_latency got=%0d exp=%0d", lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.move !== exp_move) $display("FAIL wrap_move got=%h exp=%h", bus.move, exp_move);
        else pass_cnt++;
        $display("probe_wrap: rng=00000033 play=4 elem=2 move=%h lat=%0d", bus.move, lat);
    endtask

    typedef struct {
        logic [31:0] r;
        logic [3:0]  p;
        logic [2:0]  e;
        logic [12:0] m;
        int          l;
    } vec_t;

    task automatic test_clamp();
        vec_t vecs[4];
        int lat;
        // 15%5=0; play 0->1 so elem 3->1; elem 7->4 with fields 1,2,3,4;
        // play 15->13 so 14%13=1.
        vecs[0] = '{32'h0000_000F, 4'd5,  3'd1, 13'h0001, 2};
        vecs[1] = '{32'h0000_0007, 4'd0,  3'd3, 13'h0001, 2};
        vecs[2] = '{32'h0000_4321, 4'd13, 3'd7, 13'h001E, 5};
        vecs[3] = '{32'h0000_000E, 4'd15, 3'd1, 13'h0002, 2};
        for (int i = 0; i < 4; i++) begin
            start_and_wait(vecs[i].r, vecs[i].p, vecs[i].e, lat);
            total_cnt++;
            if (lat !== vecs[i].l) $display("FAIL clamp%0d_latency got=%0d exp=%0d", i, lat, vecs[i].l);
            else pass_cnt++;
            total_cnt++;
            if (bus.move !== vecs[i].m) $display("FAIL clamp%0d_move got=%h exp=%h", i, bus.move, vecs[i].m);
            else pass_cnt++;
            $display("clamp%0d: rng=%h play=%0d elem=%0d move=%h lat=%0d",
                     i, vecs[i].r, vecs[i].p, vecs[i].e, bus.move, lat);
        end
    endtask

    task automatic test_handshake();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.rng = 32'h0000_0021; bus.num_play = 4'd13; bus.num_elements = 3'd2;
        @(negedge clk);                 // cycle 1
        bus.start = 1'b0;
        @(negedge clk);                 // cycle 2, busy: this start must be ignored
        bus.start = 1'b1; bus.rng = 32'h0000_0043; bus.num_elements = 3'd1;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL hs_busy got=%b exp=1", bus.busy);
        else pass_cnt++;
        @(negedge clk);                 // cycle 3
        bus.start = 1'b0;
        total_cnt++;
        if (bus.done !== 1'b1) $display("FAIL hs_done got=%b exp=1", bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.move !== 13'h0006) $display("FAIL hs_move got=%h exp=%h", bus.move, 13'h0006);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL hs_done_pulse got=%b exp=0", bus.done);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if (bus.valid !== 1'b1 || bus.move !== 13'h0006)
                $display("FAIL hs_hold%0d got valid=%b move=%h exp valid=1 move=0006", i, bus.valid, bus.move);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.start = 1'b1; bus.rng = 32'h0000_4321; bus.num_play = 4'd13; bus.num_elements = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        total_cnt++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL hs_restart got valid=%b busy=%b exp valid=0 busy=1", bus.valid, bus.busy);
        else pass_cnt++;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat !== 5 || bus.move !== 13'h001E)
            $display("FAIL hs_second got lat=%0d move=%h exp lat=5 move=001e", lat, bus.move);
        else pass_cnt++;
        $display("handshake: second move=%h lat=%0d", bus.move, lat);
    endtask

    task automatic test_reset_mid_op();
        int  lat;
        logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.rng = 32'h0000_0011; bus.num_play = 4'd13; bus.num_elements = 3'd2;
        @(negedge clk);                 // cycle 1
        bus.start = 1'b0;
        @(negedge clk);                 // cycle 2
`ifdef MOVE_DISTINCT_EN
        @(negedge clk);                 // cycle 3: PROBE
`endif
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.move !== 13'h0 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL midrst_outputs got move=%h busy=%b valid=%b done=%b exp all 0",
                     bus.move, bus.busy, bus.valid, bus.done);
        else pass_cnt++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done !== 1'b0) $display("FAIL midrst_no_done got=%b exp=0", saw_done);
        else pass_cnt++;
        start_and_wait(32'h0000_0021, 4'd13, 3'd2, lat);
        total_cnt++;
        if (lat !== 3 || bus.move !== 13'h0006)
            $display("FAIL midrst_recover got lat=%0d move=%h exp lat=3 move=0006", lat, bus.move);
        else pass_cnt++;
        $display("reset_mid_op: recovery move=%h lat=%0d", bus.move, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        bus.start        = 1'b0;
        bus.rng          = '0;
        bus.num_play     = '0;
        bus.num_elements = '0;
        test_reset();
        test_basic();
        test_collision();
        test_probe_wrap();
        test_clamp();
        test_handshake();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
